nic_out_pkt_queue: RTL and testbench
====================================

// Module: nic_out_pkt_queue
// PURPOSE
//  Multi-slot successor of the NIC single-packet output buffer: queues up to N_SLOTS whole
//  packets from the NIC core, requests a VC from the VA, serialises each packet into flits
//  towards the router link under per-VC credit flow control, and releases the VC when the
//  tail flit leaves. Sits between the NIC packet builder and the link allocator / router input port.
// PARAMETERS
//  FLIT_WIDTH      16  bits per flit
//  MAX_PKT_LEN     5   max flits per packet; pkt_i width = MAX_PKT_LEN*FLIT_WIDTH
//  N_SLOTS         4   packet slots (power of 2, >=2)
//  N_VN            2   virtual networks
//  N_VC_PER_VN     2   VCs per VN; one-hot VC vector width N_VC = N_VN*N_VC_PER_VN
//  MAX_CREDIT      4   per-VC credit count at reset (router input buffer depth)
//  N_BITS_VNET_ID  clog2(N_VN); N_BITS_LEN = clog2(MAX_PKT_LEN+1); N_BITS_CREDIT = clog2(MAX_CREDIT+1)
// PORTS
//  clk                 in   1                   clock, all logic on posedge
//  rst                 in   1                   reset, asynchronous, active-high
//  pkt_i               in   MAX_PKT_LEN*FLIT_W  packet, flit k = pkt_i[k*FLIT_WIDTH +: FLIT_WIDTH]
//  pkt_len_i           in   N_BITS_LEN          flits in packet, 1..MAX_PKT_LEN
//  vnet_id_i           in   N_BITS_VNET_ID      VN of packet
//  is_valid_i          in   1                   enqueue strobe
//  free_slot_o         out  1                   >=1 slot empty
//  r_va_o              out  1                   VC request for head packet
//  vnet_id_o           out  N_BITS_VNET_ID      VN of head packet
//  g_va_i              in   1                   VA grant
//  vc_id_i             in   N_VC                granted VC, one-hot
//  r_la_o              out  1                   link request (VC held and credit > 0)
//  g_la_i              in   1                   link grant, one flit per grant
//  flit_o              out  FLIT_WIDTH          output flit
//  is_valid_o          out  1                   flit_o valid
//  credit_in_i         in   N_VC                credit return, one bit per VC, any subset per cycle
//  release_pointer_o   out  1                   one-cycle pulse: tail sent, VC released
//  vc_id_o             out  N_VC                VC being released / in use (one-hot)
// BEHAVIOUR
//  Reset: all outputs 0 except free_slot_o=1; slots empty, rd/wr pointers 0, FSM IDLE,
//   every credit counter = MAX_CREDIT. Reset mid-packet drops all queued/partial packets.
//  Enqueue: is_valid_i & free_slot_o writes pkt/len/vnet into slot[wr_ptr], wr_ptr++ (wraps
//   mod N_SLOTS). is_valid_i while full is ignored (packet dropped). Occupancy counter
//   N_SLOTS+1 states; enqueue and dequeue in same cycle leave count unchanged.
//  FSM IDLE: slot[rd_ptr] occupied -> VA next cycle (enqueue->r_va_o latency 1 cycle min).
//  FSM VA: r_va_o=1, vnet_id_o=slot VN. g_va_i -> latch vc_id_i into vc_reg, flit_cnt=0, -> SEND.
//   g_va_i outside VA ignored.
//  FSM SEND: r_la_o = (credit[vc_reg] != 0), combinational from registered state.
//   g_la_i & r_la_o: next cycle flit_o = flit[flit_cnt], is_valid_o=1; credit[vc_reg]--;
//   flit_cnt++. g_la_i without r_la_o ignored; is_valid_o=0 on all cycles with no accepted grant.
//   On grant for flit pkt_len-1: release_pointer_o=1 and vc_id_o=vc_reg with the tail flit,
//   slot freed, rd_ptr++ (wrap), -> IDLE. Back-to-back packets: >=2 idle cycles between tail
//   and next r_va_o (IDLE, VA).
//  vc_id_o = vc_reg while in SEND, 0 otherwise.
//  Credits: credit[v] += credit_in_i[v]; decrement on accepted grant to v; both in same cycle
//   -> unchanged. Increment at MAX_CREDIT saturates (no wrap). Credits are per VC and persist
//   across packets.
// CONFIGURATION
//  NIC_OUT_QUEUE_ERR_EN defined: extra output err_o[2:0], sticky until rst:
//   [0] enqueue while full, [1] credit return at MAX_CREDIT, [2] g_la_i while r_la_o=0.
//  Undefined: port absent, those events silently ignored as above; no other difference.
// TESTING
//  1 Reset -> free_slot_o=1, r_va_o=r_la_o=is_valid_o=0, credits 4 (probe via 4 grants).
//  2 Enqueue pkt_i=80'hFFF2DDD1CCC1BBB10000, len 5, VN 1; g_va_i with vc_id_i=4'b0100 ->
//    five grants yield flits 0000,BBB1,CCC1,DDD1,FFF2; tail cycle release_pointer_o=1,
//    vc_id_o=0100.
//  3 Credit stall: same packet, no credit_in_i -> r_la_o drops after 4 flits; credit_in_i=0100
//    for 1 cycle -> r_la_o=1, 5th flit sent; credit for VC2 ends at 0.
//  4 Fill 4 slots (free_slot_o=0), 5th enqueue dropped (err_o[0]=1 with ERR_EN); drain ->
//    packets emerge in order, pointers wrap, free_slot_o=1 after first tail.
//  5 Simultaneous credit_in_i and accepted grant on same VC -> count unchanged;
//    credit_in_i at 4 -> stays 4.
//  6 Assert rst mid-packet (after 2 flits) -> all outputs to reset values immediately,
//    queue empty, no release_pointer_o pulse.

Source files
------------

// File: rtl/nic_out_pkt_queue_if.sv
// nic_out_pkt_queue_if
//  Bundles every non-clock/reset signal of nic_out_pkt_queue.
//  Modports:
//   master - packet source, VC/link allocators and router credit path (drives *_i)
//   slave  - the queue itself (drives *_o and dbg_state)
//  Signals:
//   pkt_i/pkt_len_i/vnet_id_i/is_valid_i : packet enqueue
//   free_slot_o                          : at least one slot empty
//   r_va_o/vnet_id_o/g_va_i/vc_id_i      : VC allocation request/grant
//   r_la_o/g_la_i                        : link request/grant, one flit per grant
//   flit_o/is_valid_o                    : outgoing flit
//   credit_in_i                          : per-VC credit return
//   release_pointer_o/vc_id_o            : tail sent / VC released, VC in use
//   dbg_state                            : current FSM state for observation
//  Handshake semantics: is_valid_i is accepted only on cycles where free_slot_o=1;
//  a VA grant counts only while r_va_o=1; a link grant counts only while r_la_o=1,
//  and each counted link grant puts exactly one flit on flit_o in the next cycle.
interface nic_out_pkt_queue_if #(
  parameter int FLIT_WIDTH  = 16,
  parameter int MAX_PKT_LEN = 5,
  parameter int N_VN        = 2,
  parameter int N_VC_PER_VN = 2
);
  localparam int N_VC           = N_VN * N_VC_PER_VN;
  localparam int N_BITS_VNET_ID = $clog2(N_VN);
  localparam int N_BITS_LEN     = $clog2(MAX_PKT_LEN + 1);

  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] pkt_i;
  logic [N_BITS_LEN-1:0]             pkt_len_i;
  logic [N_BITS_VNET_ID-1:0]         vnet_id_i;
  logic                              is_valid_i;
  logic                              free_slot_o;
  logic                              r_va_o;
  logic [N_BITS_VNET_ID-1:0]         vnet_id_o;
  logic                              g_va_i;
  logic [N_VC-1:0]                   vc_id_i;
  logic                              r_la_o;
  logic                              g_la_i;
  logic [FLIT_WIDTH-1:0]             flit_o;
  logic                              is_valid_o;
  logic [N_VC-1:0]                   credit_in_i;
  logic                              release_pointer_o;
  logic [N_VC-1:0]                   vc_id_o;
  logic [1:0]                        dbg_state;

  modport master (
    output pkt_i, pkt_len_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i, g_la_i, credit_in_i,
    input  free_slot_o, r_va_o, vnet_id_o, r_la_o, flit_o, is_valid_o,
           release_pointer_o, vc_id_o, dbg_state
  );

  modport slave (
    input  pkt_i, pkt_len_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i, g_la_i, credit_in_i,
    output free_slot_o, r_va_o, vnet_id_o, r_la_o, flit_o, is_valid_o,
           release_pointer_o, vc_id_o, dbg_state
  );
endinterface

// File: rtl/nic_out_pkt_queue.sv
// nic_out_pkt_queue
//  Multi-slot NIC output queue: stores up to N_SLOTS whole packets, requests a VC
//  for the head packet, serialises it into flits under per-VC credit flow control
//  and releases the VC together with the tail flit.
//  Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - nic_out_pkt_queue_if.slave (enqueue, VA, LA, flit, credit, release)
//   err_o[2:0] - only when NIC_OUT_QUEUE_ERR_EN is defined; sticky until rst:
//                [0] enqueue while full, [1] credit return at MAX_CREDIT,
//                [2] link grant while r_la_o=0
//  Optional feature macro: NIC_OUT_QUEUE_ERR_EN
module nic_out_pkt_queue #(
  parameter int FLIT_WIDTH  = 16,
  parameter int MAX_PKT_LEN = 5,
  parameter int N_SLOTS     = 4,
  parameter int N_VN        = 2,
  parameter int N_VC_PER_VN = 2,
  parameter int MAX_CREDIT  = 4
) (
  input logic clk,
  input logic rst,
  nic_out_pkt_queue_if.slave bus
`ifdef NIC_OUT_QUEUE_ERR_EN
  ,
  output logic [2:0] err_o
`endif
);
  localparam int N_VC           = N_VN * N_VC_PER_VN;
  localparam int N_BITS_VNET_ID = $clog2(N_VN);
  localparam int N_BITS_LEN     = $clog2(MAX_PKT_LEN + 1);
  localparam int N_BITS_CREDIT  = $clog2(MAX_CREDIT + 1);
  localparam int PTR_W          = $clog2(N_SLOTS);
  localparam int CNT_W          = $clog2(N_SLOTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VA   = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [N_VC-1:0]           vc_reg_q, vc_reg_d;
  logic [N_BITS_LEN-1:0]     flit_cnt_q, flit_cnt_d;
  logic [FLIT_WIDTH-1:0]     flit_q, flit_d;
  logic                      valid_q, valid_d;
  logic                      release_q, release_d;
  logic [N_BITS_CREDIT-1:0]  credit_q [N_VC];
  logic [N_BITS_CREDIT-1:0]  credit_d [N_VC];

  // Slot storage has no reset: a slot is only read after it has been written.
  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] slot_pkt_q [N_SLOTS];
  logic [N_BITS_LEN-1:0]             slot_len_q [N_SLOTS];
  logic [N_BITS_VNET_ID-1:0]         slot_vn_q  [N_SLOTS];

  logic                      full;
  logic                      enq;
  logic                      la_req;
  logic                      la_accept;
  logic                      tail;
  logic [N_BITS_CREDIT-1:0]  cur_credit;
  logic [N_BITS_LEN-1:0]     head_len;
  logic [FLIT_WIDTH-1:0]     head_flits [MAX_PKT_LEN];

  assign full     = (count_q == CNT_W'(N_SLOTS));
  assign enq      = bus.is_valid_i & ~full;
  assign head_len = slot_len_q[rd_ptr_q];

  always_comb begin
    for (int k = 0; k < MAX_PKT_LEN; k++) begin
      head_flits[k] = slot_pkt_q[rd_ptr_q][k*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // vc_reg is one-hot, so OR-ing the masked counters selects the held VC's credit.
  always_comb begin
    cur_credit = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (vc_reg_q[v]) cur_credit = cur_credit | credit_q[v];
    end
  end

  assign la_req    = (state_q == ST_SEND) && (cur_credit != '0);
  assign la_accept = la_req & bus.g_la_i;
  assign tail      = la_accept && (flit_cnt_q == head_len - N_BITS_LEN'(1));

  always_ff @(posedge clk) begin
    if (enq) begin
      slot_pkt_q[wr_ptr_q] <= bus.pkt_i;
      slot_len_q[wr_ptr_q] <= bus.pkt_len_i;
      slot_vn_q[wr_ptr_q]  <= bus.vnet_id_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    vc_reg_d   = vc_reg_q;
    flit_cnt_d = flit_cnt_q;
    flit_d     = '0;
    valid_d    = 1'b0;
    release_d  = 1'b0;

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    // Dequeue happens only on the tail grant; simultaneous enqueue cancels it out.
    if (enq && !tail)      count_d = count_q + CNT_W'(1);
    else if (!enq && tail) count_d = count_q - CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_VA;
      end
      ST_VA: begin
        if (bus.g_va_i) begin
          vc_reg_d   = bus.vc_id_i;
          flit_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (la_accept) begin
          flit_d     = head_flits[flit_cnt_q];
          valid_d    = 1'b1;
          flit_cnt_d = flit_cnt_q + N_BITS_LEN'(1);
          if (tail) begin
            release_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return and consumption on the same VC in one cycle cancel; returns saturate.
  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      credit_d[v] = credit_q[v];
      if (bus.credit_in_i[v] && !(la_accept && vc_reg_q[v])) begin
        if (credit_q[v] != N_BITS_CREDIT'(MAX_CREDIT)) credit_d[v] = credit_q[v] + N_BITS_CREDIT'(1);
      end else if (!bus.credit_in_i[v] && la_accept && vc_reg_q[v]) begin
        credit_d[v] = credit_q[v] - N_BITS_CREDIT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vc_reg_q   <= '0;
      flit_cnt_q <= '0;
      flit_q     <= '0;
      valid_q    <= 1'b0;
      release_q  <= 1'b0;
      for (int v = 0; v < N_VC; v++) credit_q[v] <= N_BITS_CREDIT'(MAX_CREDIT);
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vc_reg_q   <= vc_reg_d;
      flit_cnt_q <= flit_cnt_d;
      flit_q     <= flit_d;
      valid_q    <= valid_d;
      release_q  <= release_d;
      for (int v = 0; v < N_VC; v++) credit_q[v] <= credit_d[v];
    end
  end

`ifdef NIC_OUT_QUEUE_ERR_EN
  logic [2:0] err_q, err_d;
  logic       cred_sat_evt;

  always_comb begin
    cred_sat_evt = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (bus.credit_in_i[v] && !(la_accept && vc_reg_q[v]) &&
          (credit_q[v] == N_BITS_CREDIT'(MAX_CREDIT))) cred_sat_evt = 1'b1;
    end
    err_d = err_q | {bus.g_la_i & ~la_req, cred_sat_evt, bus.is_valid_i & full};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`endif

  assign bus.free_slot_o       = ~full;
  assign bus.r_va_o            = (state_q == ST_VA);
  assign bus.vnet_id_o         = (state_q == ST_VA) ? slot_vn_q[rd_ptr_q] : '0;
  assign bus.r_la_o            = la_req;
  assign bus.flit_o            = flit_q;
  assign bus.is_valid_o        = valid_q;
  assign bus.release_pointer_o = release_q;
  // The tail cycle is already IDLE, so the released VC is shown alongside the pulse.
  assign bus.vc_id_o           = ((state_q == ST_SEND) || release_q) ? vc_reg_q : '0;
  assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_nic_out_pkt_queue.sv
module tb_nic_out_pkt_queue;
  localparam int FLIT_WIDTH  = 16;
  localparam int MAX_PKT_LEN = 5;
  localparam int N_SLOTS     = 4;
  localparam int N_VN        = 2;
  localparam int N_VC_PER_VN = 2;
  localparam int MAX_CREDIT  = 4;
  localparam int N_VC        = N_VN * N_VC_PER_VN;
  localparam int PW          = MAX_PKT_LEN * FLIT_WIDTH;
  localparam int EW          = 1 + N_VC + FLIT_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nic_out_pkt_queue_if #(
    .FLIT_WIDTH(FLIT_WIDTH), .MAX_PKT_LEN(MAX_PKT_LEN), .N_VN(N_VN), .N_VC_PER_VN(N_VC_PER_VN)
  ) bus ();

`ifdef NIC_OUT_QUEUE_ERR_EN
  logic [2:0] err_o;
`endif

  nic_out_pkt_queue #(
    .FLIT_WIDTH(FLIT_WIDTH), .MAX_PKT_LEN(MAX_PKT_LEN), .N_SLOTS(N_SLOTS),
    .N_VN(N_VN), .N_VC_PER_VN(N_VC_PER_VN), .MAX_CREDIT(MAX_CREDIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef NIC_OUT_QUEUE_ERR_EN
    ,
    .err_o(err_o)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [PW-1:0] data;
    int            len;
    int            vn;
  } pkt_t;

  pkt_t                 m_q[$];     // packets held in the queue, head first
  int                   m_phase;    // 0 waiting for a head packet, 1 requesting VC, 2 sending
  int                   m_vc;       // index of granted VC
  int                   m_sent;     // flits of head packet already sent
  int                   m_cred[N_VC];
  bit                   m_valid;
  bit                   m_rel;
  logic [FLIT_WIDTH-1:0] m_flit;

  // Emitted flits as {release, vc_id, flit}, in order.
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_phase = 0;
    m_vc    = 0;
    m_sent  = 0;
    m_valid = 1'b0;
    m_rel   = 1'b0;
    m_flit  = '0;
    for (int v = 0; v < N_VC; v++) m_cred[v] = MAX_CREDIT;
  endfunction

  function automatic int onehot_idx(input logic [N_VC-1:0] oh);
    int r = 0;
    for (int v = 0; v < N_VC; v++) if (oh[v]) r = v;
    return r;
  endfunction

  // Advance the model by one clock using the inputs present this cycle.
  function automatic void model_step();
    bit            acc;
    bit            is_tail;
    int            sz;
    logic [PW-1:0] d;
    acc     = (m_phase == 2) && (m_cred[m_vc] != 0) && (bus.g_la_i == 1'b1);
    sz      = m_q.size();
    is_tail = 1'b0;
    m_valid = acc;
    m_rel   = 1'b0;
    m_flit  = '0;
    if (acc) begin
      d       = m_q[0].data;
      m_flit  = d[m_sent*FLIT_WIDTH +: FLIT_WIDTH];
      is_tail = (m_sent == m_q[0].len - 1);
      m_rel   = is_tail;
    end
    for (int v = 0; v < N_VC; v++) begin
      bit inc, dec;
      inc = bus.credit_in_i[v];
      dec = acc && (v == m_vc);
      if (inc && !dec && m_cred[v] < MAX_CREDIT) m_cred[v] = m_cred[v] + 1;
      else if (dec && !inc)                      m_cred[v] = m_cred[v] - 1;
    end
    case (m_phase)
      0: if (sz != 0) m_phase = 1;
      1: if (bus.g_va_i) begin
           m_vc    = onehot_idx(bus.vc_id_i);
           m_sent  = 0;
           m_phase = 2;
         end
      default: if (acc) begin
           m_sent = m_sent + 1;
           if (is_tail) begin
             void'(m_q.pop_front());
             m_phase = 0;
           end
         end
    endcase
    if (bus.is_valid_i && sz < N_SLOTS)
      m_q.push_back('{data: bus.pkt_i, len: int'(bus.pkt_len_i), vn: int'(bus.vnet_id_i)});
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [N_VC-1:0] exp_vcid;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      exp_vcid = (m_phase == 2 || m_rel) ? N_VC'(1 << m_vc) : '0;
      check("free_slot_o", 64'(bus.free_slot_o), 64'(m_q.size() < N_SLOTS));
      check("r_va_o", 64'(bus.r_va_o), 64'(m_phase == 1));
      check("vnet_id_o", 64'(bus.vnet_id_o), (m_phase == 1) ? 64'(m_q[0].vn) : 64'(0));
      check("r_la_o", 64'(bus.r_la_o), 64'(m_phase == 2 && m_cred[m_vc] != 0));
      check("is_valid_o", 64'(bus.is_valid_o), 64'(m_valid));
      check("release_pointer_o", 64'(bus.release_pointer_o), 64'(m_rel));
      check("vc_id_o", 64'(bus.vc_id_o), 64'(exp_vcid));
      if (m_valid) begin
        check("flit_o", 64'(bus.flit_o), 64'(m_flit));
        exp_q.push_back({m_rel, exp_vcid, m_flit});
      end
      if (!rst) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pkt_i       = '0;
    bus.pkt_len_i   = '0;
    bus.vnet_id_i   = '0;
    bus.is_valid_i  = 1'b0;
    bus.g_va_i      = 1'b0;
    bus.vc_id_i     = '0;
    bus.g_la_i      = 1'b0;
    bus.credit_in_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic set_pkt(input logic [PW-1:0] d, input int len, input int vn);
    bus.pkt_i      = d;
    bus.pkt_len_i  = 3'(len);
    bus.vnet_id_i  = 1'(vn);
    bus.is_valid_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [FLIT_WIDTH-1:0] lit5 [5] = '{16'h0000, 16'hBBB1, 16'hCCC1, 16'hDDD1, 16'hFFF2};
  localparam logic [PW-1:0] PKT_A = 80'hFFF2DDD1CCC1BBB10000;

  initial begin
    logic [FLIT_WIDTH-1:0] exp_flits[$];
    logic [PW-1:0]         d;
    int                    tbl_len [4];
    int                    n_rel;
    tbl_len = '{3, 1, 5, 2};

    idle_inputs();
    #1 rst = 1'b1;
    cyc(3);
    check("reset_free_slot", 64'(bus.free_slot_o), 64'(1));
    check("reset_is_valid", 64'(bus.is_valid_o), 64'(0));
    rst = 1'b0;

    // Single packet, four credits, stall, one credit return, tail.
    exp_q.delete();
    set_pkt(PKT_A, 5, 1);
    bus.g_va_i  = 1'b1;
    bus.vc_id_i = 4'b0100;
    bus.g_la_i  = 1'b1;
    cyc();
    bus.is_valid_i = 1'b0;
    cyc(12);
    check("stall_r_la", 64'(bus.r_la_o), 64'(0));
    check("stall_flits", 64'(exp_q.size()), 64'(4));
    bus.credit_in_i = 4'b0100;
    cyc();
    bus.credit_in_i = '0;
    cyc(5);
    bus.g_va_i = 1'b0;
    bus.g_la_i = 1'b0;
    check("pkt_a_count", 64'(exp_q.size()), 64'(5));
    for (int k = 0; k < 5 && k < exp_q.size(); k++) begin
      check("pkt_a_flit", 64'(exp_q[k][FLIT_WIDTH-1:0]), 64'(lit5[k]));
      check("pkt_a_rel", 64'(exp_q[k][EW-1]), 64'(k == 4));
      check("pkt_a_vcid", 64'(exp_q[k][EW-2:FLIT_WIDTH]), 64'(4'b0100));
    end
    check("vc2_credit_empty", 64'(m_cred[2]), 64'(0));

    // Refill VC2 past its maximum, then send with credit return every cycle.
    bus.credit_in_i = 4'b0100;
    cyc(5);
    bus.credit_in_i = '0;
    cyc();
    check("vc2_credit_sat", 64'(m_cred[2]), 64'(4));
    exp_q.delete();
    set_pkt(PKT_A, 5, 0);
    bus.g_va_i      = 1'b1;
    bus.vc_id_i     = 4'b0100;
    bus.g_la_i      = 1'b1;
    bus.credit_in_i = 4'b0100;
    cyc();
    bus.is_valid_i = 1'b0;
    cyc(10);
    idle_inputs();
    cyc();
    check("simul_count", 64'(exp_q.size()), 64'(5));
    check("simul_credit", 64'(m_cred[2]), 64'(4));

    // Fill all slots, drop a fifth, then drain in order.
    do_reset();
    exp_q.delete();
    exp_flits.delete();
    for (int i = 0; i < 5; i++) begin
      d = '0;
      for (int k = 0; k < MAX_PKT_LEN; k++) d[k*FLIT_WIDTH +: FLIT_WIDTH] = 16'((i + 1) * 256 + k);
      set_pkt(d, (i < 4) ? tbl_len[i] : 5, i % 2);
      if (i < 4) for (int k = 0; k < tbl_len[i]; k++) exp_flits.push_back(16'((i + 1) * 256 + k));
      cyc();
    end
    bus.is_valid_i = 1'b0;
    check("full_free_slot", 64'(bus.free_slot_o), 64'(0));
    check("full_model_size", 64'(m_q.size()), 64'(4));
`ifdef NIC_OUT_QUEUE_ERR_EN
    check("err_full", 64'(err_o[0]), 64'(1));
`endif
    bus.g_la_i      = 1'b1;
    bus.credit_in_i = 4'b1111;
    for (int j = 0; j < 60; j++) begin
      bus.g_va_i  = 1'b1;
      bus.vc_id_i = 4'(1 << (j % 4));
      cyc();
    end
    idle_inputs();
    cyc();
    check("drain_count", 64'(exp_q.size()), 64'(exp_flits.size()));
    n_rel = 0;
    for (int k = 0; k < exp_q.size() && k < exp_flits.size(); k++) begin
      check("drain_flit", 64'(exp_q[k][FLIT_WIDTH-1:0]), 64'(exp_flits[k]));
      n_rel = n_rel + int'(exp_q[k][EW-1]);
    end
    check("drain_tails", 64'(n_rel), 64'(4));

    // Reset while a packet is mid-flight.
    do_reset();
    exp_q.delete();
    set_pkt(PKT_A, 5, 1);
    bus.g_va_i  = 1'b1;
    bus.vc_id_i = 4'b0001;
    bus.g_la_i  = 1'b1;
    cyc();
    bus.is_valid_i = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() < 2; i++) cyc();
    check("midrst_pre_flits", 64'(exp_q.size()), 64'(2));
    rst = 1'b1;
    #1;
    check("midrst_free_slot", 64'(bus.free_slot_o), 64'(1));
    check("midrst_r_va", 64'(bus.r_va_o), 64'(0));
    check("midrst_r_la", 64'(bus.r_la_o), 64'(0));
    check("midrst_is_valid", 64'(bus.is_valid_o), 64'(0));
    check("midrst_release", 64'(bus.release_pointer_o), 64'(0));
    check("midrst_vc_id", 64'(bus.vc_id_o), 64'(0));
    cyc(2);
    rst = 1'b0;
    cyc(10);
    check("midrst_no_more_flits", 64'(exp_q.size()), 64'(2));
    idle_inputs();

    // Randomised traffic.
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      bus.is_valid_i  = ($urandom_range(0, 3) == 0);
      bus.pkt_i       = PW'({$urandom(), $urandom(), $urandom()});
      bus.pkt_len_i   = 3'($urandom_range(1, MAX_PKT_LEN));
      bus.vnet_id_i   = 1'($urandom_range(0, N_VN - 1));
      bus.g_va_i      = 1'($urandom_range(0, 1));
      bus.vc_id_i     = 4'(1 << $urandom_range(0, N_VC - 1));
      bus.g_la_i      = ($urandom_range(0, 3) != 0);
      bus.credit_in_i = 4'($urandom() & $urandom());
      cyc();
    end
    idle_inputs();
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
